// File: rtl/i2s_rx.sv
// i2s_rx: I2S / left-justified serial audio receiver, deserializes BCK/WS/DIN into 16-bit stereo pairs.
module i2s_rx #(
    parameter bit PHILIPS = 1'b0,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        i2s_bck,
    input  logic        i2s_ws,
    input  logic        i2s_din,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        audio_valid,
    output logic        short_err,
    output logic        active
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    logic [2:0]    bck_q;
    logic [1:0]    ws_q, din_q;
    logic          ws_prev_q, ws_eff_prev_q, synced_q, chan_q, l_ok_q;
    logic [4:0]    bit_cnt_q;
    logic [15:0]   shift_q, hold_l_q;
    logic [TW-1:0] to_cnt_q;
    logic          rise_d, ws_eff_d, slot_start_d;
    logic [15:0]   word_d;
    always_comb begin
        rise_d       = bck_q[1] & ~bck_q[2];
        ws_eff_d     = PHILIPS ? ws_prev_q : ws_q[1];
        slot_start_d = rise_d & (ws_eff_d != ws_eff_prev_q);
        word_d       = {shift_q[14:0], din_q[1]};
    end
    always_ff @(posedge clk32) begin
        if (reset) begin
            bck_q         <= '0;
            ws_q          <= '0;
            din_q         <= '0;
            ws_prev_q     <= 1'b0;
            ws_eff_prev_q <= 1'b0;
            synced_q      <= 1'b0;
            chan_q        <= 1'b0;
            l_ok_q        <= 1'b0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            hold_l_q      <= '0;
            to_cnt_q      <= '0;
            audio_l       <= '0;
            audio_r       <= '0;
            audio_valid   <= 1'b0;
            short_err     <= 1'b0;
            active        <= 1'b0;
        end else begin
            bck_q       <= {bck_q[1:0], i2s_bck};
            ws_q        <= {ws_q[0], i2s_ws};
            din_q       <= {din_q[0], i2s_din};
            audio_valid <= 1'b0;
            short_err   <= 1'b0;
            if (rise_d) begin
                to_cnt_q      <= '0;
                active        <= 1'b1;
                ws_prev_q     <= ws_q[1];
                ws_eff_prev_q <= ws_eff_d;
                if (slot_start_d) begin
                    synced_q  <= 1'b1;
                    bit_cnt_q <= 5'd1;
                    shift_q   <= {15'b0, din_q[1]};
                    chan_q    <= ws_eff_d;
                    if (synced_q && bit_cnt_q < 5'd16) begin
                        short_err <= 1'b1;
                        l_ok_q    <= 1'b0;
                    end
                end else if (synced_q && bit_cnt_q < 5'd16) begin
                    shift_q   <= word_d;
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                    // 16th bit of the slot completes a word
                    if (bit_cnt_q == 5'd15) begin
                        if (!chan_q) begin
                            hold_l_q <= word_d;
                            l_ok_q   <= 1'b1;
                        end else if (l_ok_q) begin
                            audio_l     <= hold_l_q;
                            audio_r     <= word_d;
                            audio_valid <= 1'b1;
                            l_ok_q      <= 1'b0;
                        end
                    end
                end
            end else if (to_cnt_q < TMAX) begin
                to_cnt_q <= to_cnt_q + 1'b1;
                if (to_cnt_q == TMAX - 1'b1) begin
                    active   <= 1'b0;
                    synced_q <= 1'b0;
                    l_ok_q   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx, left-justified and Philips instances sharing clock, reset and BCK.
module tb_i2s_rx;
    logic        clk32 = 1'b0, reset = 1'b1, bck = 1'b0;
    logic        ws0 = 1'b0, din0 = 1'b0, ws1 = 1'b0, din1 = 1'b0, sel = 1'b0;
    logic [15:0] l0, r0, l1, r1;
    logic        v0, v1, se0, se1, act0, act1;
    int          compared = 0, mismatched = 0, cyc = 0, last_rise = 0;
    logic [31:0] q0[$], q1[$];
    logic        sq0[$];

    always #5 clk32 = ~clk32;
    always @(posedge clk32) cyc <= cyc + 1;

    i2s_rx #(.PHILIPS(1'b0), .TIMEOUT(1024)) u0 (
        .clk32(clk32), .reset(reset), .i2s_bck(bck), .i2s_ws(ws0), .i2s_din(din0),
        .audio_l(l0), .audio_r(r0), .audio_valid(v0), .short_err(se0), .active(act0));
    i2s_rx #(.PHILIPS(1'b1), .TIMEOUT(1024)) u1 (
        .clk32(clk32), .reset(reset), .i2s_bck(bck), .i2s_ws(ws1), .i2s_din(din1),
        .audio_l(l1), .audio_r(r1), .audio_valid(v1), .short_err(se1), .active(act1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk32) begin
        if (v0) begin
            if (q0.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL u0_pair: unexpected valid with %h/%h, none pending", l0, r0);
            end else check("u0_pair", {l0, r0}, q0.pop_front());
        end
        if (se0) begin
            if (sq0.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL u0_short: unexpected short_err pulse");
            end else begin
                void'(sq0.pop_front());
                check("u0_short_excl_valid", {31'b0, v0}, 32'h0);
            end
        end
        if (v1) begin
            if (q1.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL u1_pair: unexpected valid with %h/%h, none pending", l1, r1);
            end else check("u1_pair", {l1, r1}, q1.pop_front());
        end
        if (se1) begin
            compared++;
            mismatched++;
            $display("FAIL u1_short: unexpected short_err pulse");
        end
    end

    task automatic bit_out(input logic w, input logic d);
        if (sel) begin
            ws1  = w;
            din1 = d;
        end else begin
            ws0  = w;
            din0 = d;
        end
        bck = 1'b0;
        repeat (11) @(negedge clk32);
        bck = 1'b1;
        last_rise = cyc;
        repeat (11) @(negedge clk32);
    endtask

    task automatic lj_slot(input logic w, input logic [15:0] word, input int n);
        for (int i = 0; i < n; i++) bit_out(w, word[15-i]);
    endtask

    task automatic lj_frame(input logic [15:0] l, input logic [15:0] r, input logic exp);
        if (exp) q0.push_back({l, r});
        lj_slot(1'b0, l, 16);
        lj_slot(1'b1, r, 16);
    endtask

    task automatic ph_slot(input logic w, input logic [15:0] word);
        logic d;
        for (int k = 0; k < 32; k++) begin
            d = 1'b0;
            if (k >= 1 && k <= 16) d = word[16-k];
            bit_out(w, d);
        end
    endtask

    task automatic ph_frame(input logic [15:0] l, input logic [15:0] r, input logic exp);
        if (exp) q1.push_back({l, r});
        ph_slot(1'b0, l);
        ph_slot(1'b1, r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_audio_l"}, {16'b0, l0}, 32'h0);
        check({tag, "_audio_r"}, {16'b0, r0}, 32'h0);
        check({tag, "_valid"}, {31'b0, v0}, 32'h0);
        check({tag, "_short"}, {31'b0, se0}, 32'h0);
        check({tag, "_active"}, {31'b0, act0}, 32'h0);
    endtask

    initial begin
        logic [15:0] w;
        repeat (4) @(negedge clk32);
        check_reset_outputs("por");
        check("por_u1_active", {31'b0, act1}, 32'h0);
        reset = 1'b0;
        // first frame has no left slot start, so its right word is dropped
        lj_frame(16'h1234, 16'hABCD, 1'b0);
        repeat (3) lj_frame(16'h1234, 16'hABCD, 1'b1);
        lj_slot(1'b0, 16'hFFFF, 10);
        sq0.push_back(1'b1);
        lj_slot(1'b1, 16'h5555, 16);
        lj_frame(16'hC3A5, 16'h5A3C, 1'b1);
        repeat (2) begin
            lj_frame(16'h8000, 16'h7FFF, 1'b1);
            lj_frame(16'h7FFF, 16'h8000, 1'b1);
        end
        lj_slot(1'b0, 16'h1111, 16);
        lj_slot(1'b1, 16'h2222, 8);
        bck   = 1'b0;
        ws0   = 1'b0;
        din0  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk32);
        check_reset_outputs("midrst");
        reset = 1'b0;
        lj_frame(16'h5A5A, 16'h0F0F, 1'b0);
        lj_frame(16'h5A5A, 16'h0F0F, 1'b1);
        lj_frame(16'hA5A5, 16'hF0F0, 1'b1);
        bck = 1'b0;
        while (cyc < last_rise + 1010) @(negedge clk32);
        check("to_active_before", {31'b0, act0}, 32'h1);
        while (cyc < last_rise + 1040) @(negedge clk32);
        check("to_active_after", {31'b0, act0}, 32'h0);
        check("to_u1_active_after", {31'b0, act1}, 32'h0);
        while (cyc < last_rise + 1100) @(negedge clk32);
        w = 16'h9357;
        q0.push_back({w, 16'h2468});
        bit_out(1'b0, w[15]);
        check("restart_active", {31'b0, act0}, 32'h1);
        for (int i = 1; i < 16; i++) bit_out(1'b0, w[15-i]);
        lj_slot(1'b1, 16'h2468, 16);
        lj_frame(16'h0001, 16'hFFFE, 1'b1);
        sel = 1'b1;
        ph_frame(16'h1234, 16'hABCD, 1'b0);
        ph_frame(16'h1234, 16'hABCD, 1'b1);
        ph_frame(16'hFEDC, 16'h0123, 1'b1);
        repeat (50) @(negedge clk32);
        check("u0_pending_pairs", q0.size(), 32'h0);
        check("u0_pending_shorts", sq0.size(), 32'h0);
        check("u1_pending_pairs", q1.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
